// File: rtl/prores_slice_pkg.sv
// Shared definitions for the ProRes slice header parser: state encoding,
// header size thresholds and fixed field widths of the bitstream format.
package prores_slice_pkg;

  localparam int HDR_SIZE_W   = 5;
  localparam int QSCALE_W     = 8;
  localparam int PLANE_SIZE_W = 16;

  localparam logic [HDR_SIZE_W-1:0] SLICE_HDR_MIN_BYTES = 5'd6;
  localparam logic [HDR_SIZE_W-1:0] SLICE_HDR_CR_BYTES  = 5'd8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_B0,
    ST_QS,
    ST_YH,
    ST_YL,
    ST_CBH,
    ST_CBL,
    ST_CRH,
    ST_CRL,
    ST_SKIP,
    ST_DONE
  } slice_state_t;

endpackage

// File: rtl/slice_header_parser.sv
// Parses the byte-aligned slice header into size/qscale/plane-size fields and
// presents them to the coefficient-unpack stage with a valid/ack handshake.
module slice_header_parser
  import prores_slice_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    hdr_valid,
  input  logic                    hdr_ack,
  output logic [HDR_SIZE_W-1:0]   hdr_size,
  output logic [QSCALE_W-1:0]     qscale,
  output logic [PLANE_SIZE_W-1:0] y_size,
  output logic [PLANE_SIZE_W-1:0] cb_size,
  output logic [PLANE_SIZE_W-1:0] cr_size,
  output logic                    cr_present,
  output logic                    hdr_error,
  output logic                    busy
);

  slice_state_t          state, next_state;
  logic [HDR_SIZE_W-1:0] byte_cnt;
  logic [HDR_SIZE_W-1:0] cnt_inc;
  logic [HDR_SIZE_W-1:0] b0_size;
  logic                  accept;
  logic                  unused_reserved;

  assign in_ready        = (state != ST_IDLE) && (state != ST_DONE);
  assign hdr_valid       = (state == ST_DONE);
  assign busy            = (state != ST_IDLE);
  assign accept          = in_valid && in_ready;
  assign cnt_inc         = byte_cnt + 5'd1;
  assign b0_size         = in_data[7:3];
  assign unused_reserved = ^in_data[2:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_B0;
      ST_B0: begin
        if (accept) begin
          next_state = (b0_size < SLICE_HDR_MIN_BYTES) ? ST_DONE : ST_QS;
        end
      end
      ST_QS:  if (accept) next_state = ST_YH;
      ST_YH:  if (accept) next_state = ST_YL;
      ST_YL:  if (accept) next_state = ST_CBH;
      ST_CBH: if (accept) next_state = ST_CBL;
      ST_CBL: begin
        if (accept) begin
          if (hdr_size == SLICE_HDR_MIN_BYTES) next_state = ST_DONE;
          else if (hdr_size >= SLICE_HDR_CR_BYTES) next_state = ST_CRH;
          else next_state = ST_SKIP;
        end
      end
      ST_CRH: if (accept) next_state = ST_CRL;
      ST_CRL: begin
        if (accept) begin
          next_state = (hdr_size == SLICE_HDR_CR_BYTES) ? ST_DONE : ST_SKIP;
        end
      end
      // Trailing bytes beyond the known fields are dropped until the header length is reached.
      ST_SKIP: if (accept && (cnt_inc == hdr_size)) next_state = ST_DONE;
      ST_DONE: if (hdr_ack) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt   <= '0;
      hdr_size   <= '0;
      qscale     <= '0;
      y_size     <= '0;
      cb_size    <= '0;
      cr_size    <= '0;
      cr_present <= 1'b0;
      hdr_error  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        byte_cnt   <= '0;
        hdr_size   <= '0;
        qscale     <= '0;
        y_size     <= '0;
        cb_size    <= '0;
        cr_size    <= '0;
        cr_present <= 1'b0;
        hdr_error  <= 1'b0;
      end
      if (accept) begin
        byte_cnt <= cnt_inc;
        case (state)
          ST_B0: begin
            hdr_size   <= b0_size;
            hdr_error  <= (b0_size < SLICE_HDR_MIN_BYTES);
            cr_present <= (b0_size >= SLICE_HDR_CR_BYTES);
          end
          ST_QS:   qscale        <= in_data;
          ST_YH:   y_size[15:8]  <= in_data;
          ST_YL:   y_size[7:0]   <= in_data;
          ST_CBH:  cb_size[15:8] <= in_data;
          ST_CBL:  cb_size[7:0]  <= in_data;
          ST_CRH:  cr_size[15:8] <= in_data;
          ST_CRL:  cr_size[7:0]  <= in_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slice_header_parser.sv
// Directed bench for slice_header_parser: nominal, Cr, skip, error,
// backpressure/handshake and mid-parse reset scenarios.
module tb_slice_header_parser;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        hdr_valid;
  logic        hdr_ack;
  logic [4:0]  hdr_size;
  logic [7:0]  qscale;
  logic [15:0] y_size;
  logic [15:0] cb_size;
  logic [15:0] cr_size;
  logic        cr_present;
  logic        hdr_error;
  logic        busy;

  int vectors;
  int miscompares;

  logic [7:0] nom_bytes [6]  = '{8'h30, 8'h04, 8'h01, 8'h3F, 8'h00, 8'h7C};
  logic [7:0] cr8_bytes [8]  = '{8'h40, 8'h08, 8'h03, 8'h19, 8'h00, 8'h7C, 8'h00, 8'h80};
  logic [7:0] cr10_bytes [10] = '{8'h50, 8'h02, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'hAA, 8'hBB};

  slice_header_parser dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .hdr_valid  (hdr_valid),
    .hdr_ack    (hdr_ack),
    .hdr_size   (hdr_size),
    .qscale     (qscale),
    .y_size     (y_size),
    .cb_size    (cb_size),
    .cr_size    (cr_size),
    .cr_present (cr_present),
    .hdr_error  (hdr_error),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_hdr(input string tag, input logic [4:0] sz, input logic [7:0] qs,
                           input logic [15:0] y, input logic [15:0] cb, input logic [15:0] cr,
                           input logic crp, input logic err);
    check({tag, ".hdr_valid"},  {31'd0, hdr_valid},  32'd1);
    check({tag, ".hdr_size"},   {27'd0, hdr_size},   {27'd0, sz});
    check({tag, ".qscale"},     {24'd0, qscale},     {24'd0, qs});
    check({tag, ".y_size"},     {16'd0, y_size},     {16'd0, y});
    check({tag, ".cb_size"},    {16'd0, cb_size},    {16'd0, cb});
    check({tag, ".cr_size"},    {16'd0, cr_size},    {16'd0, cr});
    check({tag, ".cr_present"}, {31'd0, cr_present}, {31'd0, crp});
    check({tag, ".hdr_error"},  {31'd0, hdr_error},  {31'd0, err});
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, ".in_ready"},   {31'd0, in_ready},   32'd0);
    check({tag, ".hdr_valid"},  {31'd0, hdr_valid},  32'd0);
    check({tag, ".busy"},       {31'd0, busy},       32'd0);
    check({tag, ".hdr_error"},  {31'd0, hdr_error},  32'd0);
    check({tag, ".cr_present"}, {31'd0, cr_present}, 32'd0);
    check({tag, ".hdr_size"},   {27'd0, hdr_size},   32'd0);
    check({tag, ".qscale"},     {24'd0, qscale},     32'd0);
    check({tag, ".y_size"},     {16'd0, y_size},     32'd0);
    check({tag, ".cb_size"},    {16'd0, cb_size},    32'd0);
    check({tag, ".cr_size"},    {16'd0, cr_size},    32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    cycle();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic ack();
    hdr_ack = 1'b1;
    cycle();
    hdr_ack = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    hdr_ack     = 1'b0;

    repeat (2) cycle();
    check_idle_reset("reset");
    reset_n = 1'b1;
    cycle();

    // Nominal 6-byte header; the byte presented alongside start is not consumed.
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h30;
    cycle();
    start    = 1'b0;
    in_valid = 1'b0;
    check("nom.busy",     {31'd0, busy},     32'd1);
    check("nom.in_ready", {31'd0, in_ready}, 32'd1);
    check("nom.not_consumed", {27'd0, hdr_size}, 32'd0);
    for (int i = 0; i < 5; i++) send(nom_bytes[i]);
    check("nom.early_valid", {31'd0, hdr_valid}, 32'd0);
    send(nom_bytes[5]);
    check_hdr("nom", 5'd6, 8'd4, 16'h013F, 16'h007C, 16'h0000, 1'b0, 1'b0);
    check("nom.in_ready_done", {31'd0, in_ready}, 32'd0);
    ack();
    check("nom.valid_after_ack", {31'd0, hdr_valid}, 32'd0);
    check("nom.busy_after_ack",  {31'd0, busy},      32'd0);
    check("nom.y_held",          {16'd0, y_size},    32'h013F);

    // 8-byte header with Cr size.
    pulse_start();
    for (int i = 0; i < 7; i++) send(cr8_bytes[i]);
    check("cr8.early_valid", {31'd0, hdr_valid}, 32'd0);
    send(cr8_bytes[7]);
    check_hdr("cr8", 5'd8, 8'd8, 16'h0319, 16'h007C, 16'h0080, 1'b1, 1'b0);
    ack();

    // 10-byte header: two trailing bytes skipped, extra byte refused.
    pulse_start();
    for (int i = 0; i < 9; i++) send(cr10_bytes[i]);
    check("cr10.skip_ready", {31'd0, in_ready}, 32'd1);
    check("cr10.early_valid", {31'd0, hdr_valid}, 32'd0);
    send(cr10_bytes[9]);
    check_hdr("cr10", 5'd10, 8'd2, 16'h0010, 16'h0020, 16'h0030, 1'b1, 1'b0);
    check("cr10.in_ready", {31'd0, in_ready}, 32'd0);
    send(8'hCC);
    check_hdr("cr10.after_cc", 5'd10, 8'd2, 16'h0010, 16'h0020, 16'h0030, 1'b1, 1'b0);
    ack();

    // Undersized header reports an error after a single byte.
    pulse_start();
    send(8'h20);
    check_hdr("err", 5'd4, 8'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("err.in_ready", {31'd0, in_ready}, 32'd0);
    send(8'h55);
    check("err.qscale_untouched", {24'd0, qscale}, 32'd0);
    ack();
    check("err.busy_after_ack", {31'd0, busy}, 32'd0);

    // Gapped input, delayed ack and a start ignored while in DONE.
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send(nom_bytes[i]);
      in_data = 8'hFF;
      cycle();
      in_data = 8'h00;
    end
    check_hdr("bp", 5'd6, 8'd4, 16'h013F, 16'h007C, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      cycle();
      check("bp.hold_valid",  {31'd0, hdr_valid}, 32'd1);
      check("bp.hold_cb",     {16'd0, cb_size},   32'h007C);
    end
    start = 1'b0;
    ack();
    check("bp.idle_after_ack", {31'd0, busy}, 32'd0);
    cycle();
    check("bp.start_ignored", {31'd0, busy}, 32'd0);

    // Reset in the middle of a header, then a clean parse.
    pulse_start();
    for (int i = 0; i < 3; i++) send(cr8_bytes[i]);
    check("rst.busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #2;
    check_idle_reset("rst.mid");
    cycle();
    reset_n = 1'b1;
    cycle();
    pulse_start();
    for (int i = 0; i < 6; i++) send(nom_bytes[i]);
    check_hdr("rst.after", 5'd6, 8'd4, 16'h013F, 16'h007C, 16'h0000, 1'b0, 1'b0);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
